// File: rtl/exec_common_pkg.sv
// Shared execute-stage definitions: ALU function encodings and op classification.
// ADD..XOR keep their original codes; the newer ops follow them.
package exec_common_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_MUL  = 4'd10,
    ALU_DIVU = 4'd11,
    ALU_REMU = 4'd12
  } e_alu_function;

  function automatic logic is_iterative(input e_alu_function f);
    return (f == ALU_MUL) || (f == ALU_DIVU) || (f == ALU_REMU);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative multiply (shift-add) and unsigned divide (restoring), one bit per cycle.
// done is asserted during the final iteration; result is that iteration's outcome.
module alu_muldiv_iter
  import exec_common_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  e_alu_function     op,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic              done,
  output logic [WIDTH-1:0]  result
);

  localparam int CW = $clog2(WIDTH + 1);

  logic             active;
  logic [CW-1:0]    cnt;
  logic             is_mul;
  logic             is_rem;
  logic [WIDTH-1:0] acc, mcand, mplier;
  logic [WIDTH-1:0] rem, quo, dvsr;
  logic [WIDTH-1:0] acc_nxt, rem_nxt, quo_nxt;
  logic [WIDTH:0]   rem_sh;
  logic             fits;

  // The trial remainder is always below 2*dvsr, so the subtraction fits in WIDTH bits.
  always_comb begin
    acc_nxt = mplier[0] ? (acc + mcand) : acc;
    rem_sh  = {rem, quo[WIDTH-1]};
    fits    = (rem_sh >= {1'b0, dvsr});
    rem_nxt = fits ? (rem_sh[WIDTH-1:0] - dvsr) : rem_sh[WIDTH-1:0];
    quo_nxt = {quo[WIDTH-2:0], fits};
    done    = active && (cnt == CW'(1));
    result  = is_mul ? acc_nxt : (is_rem ? rem_nxt : quo_nxt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active <= 1'b0;
      cnt    <= '0;
      is_mul <= 1'b0;
      is_rem <= 1'b0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      rem    <= '0;
      quo    <= '0;
      dvsr   <= '0;
    end else if (start) begin
      active <= 1'b1;
      cnt    <= CW'(WIDTH);
      is_mul <= (op == ALU_MUL);
      is_rem <= (op == ALU_REMU);
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
      rem    <= '0;
      quo    <= a;
      dvsr   <= b;
    end else if (active) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      rem    <= rem_nxt;
      quo    <= quo_nxt;
      cnt    <= cnt - 1'b1;
      if (cnt == CW'(1)) active <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle logic/arith/shift/compare ops plus iterative MUL/DIVU/REMU.
// state | meaning: IDLE accepting request; BUSY iterative op running; DONE result held until out_ready.
module alu_multicycle
  import exec_common_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  op1,
  input  logic [WIDTH-1:0]  op2,
  input  e_alu_function     alu_function,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  res,
  output logic              busy
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic             accept;
  logic             start;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] single_res;
  logic [WIDTH-1:0] iter_result;
  logic             iter_done;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign accept    = in_valid && in_ready;
  assign start     = accept && is_iterative(alu_function);
  assign shamt     = op2[SHW-1:0];

  always_comb begin
    single_res = '0;
    case (alu_function)
      ALU_ADD:  single_res = op1 + op2;
      ALU_SUB:  single_res = op1 - op2;
      ALU_AND:  single_res = op1 & op2;
      ALU_OR:   single_res = op1 | op2;
      ALU_XOR:  single_res = op1 ^ op2;
      ALU_SLL:  single_res = op1 << shamt;
      ALU_SRL:  single_res = op1 >> shamt;
      ALU_SRA:  single_res = $unsigned($signed(op1) >>> shamt);
      ALU_SLT:  single_res = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
      ALU_SLTU: single_res = {{(WIDTH-1){1'b0}}, (op1 < op2)};
      default:  single_res = '0;
    endcase
  end

  alu_muldiv_iter #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (alu_function),
    .a      (op1),
    .b      (op2),
    .done   (iter_done),
    .result (iter_result)
  );

  // res is written only when entering DONE, so it stays stable through backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      res   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_iterative(alu_function)) begin
              state <= BUSY;
            end else begin
              state <= DONE;
              res   <= single_res;
            end
          end
        end
        BUSY: begin
          if (iter_done) begin
            state <= DONE;
            res   <= iter_result;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
